// File: rtl/uart_byte_tx.sv
// uart_byte_tx -- serial byte transmitter, frame-compatible with uart_byte_rx.
//
// Accepts one byte on a single-cycle start strobe. Sends it LSB-first in a
// UART frame: start bit, 8 data bits, optional parity bit, then 1 or 2 stop
// bits. Each bit lasts BAUD_CNT_MAX clocks.
//
// Ports:
//   i_sysclk        system clock, rising edge
//   i_sysrst_n      asynchronous active-low reset
//   i_tx_data[7:0]  byte to send; sampled only when a start is accepted
//   i_tx_start      start strobe; ignored while o_tx_busy is high
//   o_uart_tx       serial line, idle high, always driven from a flop
//   o_tx_busy       high while a frame is in progress
//   o_uart_tx_done  one-cycle pulse on the edge that ends the last stop bit
module uart_byte_tx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD,
  parameter int PARITY       = 0,  // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1   // 1 or 2
) (
  input  logic       i_sysclk,
  input  logic       i_sysrst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_start,
  output logic       o_uart_tx,
  output logic       o_tx_busy,
  output logic       o_uart_tx_done
);

  // A one-clock bit time still needs a 1-bit counter.
  localparam int CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic             stop_idx_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end;

  assign bit_end = (baud_cnt_q == CNT_LAST);

  // The line value for the next bit is loaded on the edge that ends the
  // current one. o_uart_tx therefore comes straight from tx_q, with no
  // combinational path from any input.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every register
      // samples pre-edge values, whatever order the statements appear in.
      done_q <= 1'b0;

      if (state_q != S_IDLE) begin
        baud_cnt_q <= bit_end ? '0 : baud_cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (i_tx_start) begin
            shift_q    <= i_tx_data;
            par_q      <= (PARITY == 1) ? ~(^i_tx_data) : (^i_tx_data);
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            tx_q      <= shift_q[1];
            if (bit_idx_q == 3'd7) begin
              if (PARITY != 0) begin
                tx_q    <= par_q;
                state_q <= S_PAR;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end
          end
        end

        S_PAR: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if ((STOP_BITS == 1) || stop_idx_q) begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_uart_tx      = tx_q;
  assign o_tx_busy      = busy_q;
  assign o_uart_tx_done = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx. Three instances share clock, reset and data:
// no parity with 1 stop bit, even parity with 2 stop bits, and odd parity
// with 2 stop bits. A short bit time keeps frames small.
module tb_uart_byte_tx;

  localparam int B = 8;  // clocks per bit

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       start0, start_e, start_o;
  logic       tx0, tx_e, tx_o;
  logic       busy0, busy_e, busy_o;
  logic       done0, done_e, done_o;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt [3];

  uart_byte_tx #(.BAUD_CNT_MAX(B), .PARITY(0), .STOP_BITS(1)) u_dut (
    .i_sysclk(clk), .i_sysrst_n(rst_n), .i_tx_data(tx_data), .i_tx_start(start0),
    .o_uart_tx(tx0), .o_tx_busy(busy0), .o_uart_tx_done(done0));

  uart_byte_tx #(.BAUD_CNT_MAX(B), .PARITY(2), .STOP_BITS(2)) u_even (
    .i_sysclk(clk), .i_sysrst_n(rst_n), .i_tx_data(tx_data), .i_tx_start(start_e),
    .o_uart_tx(tx_e), .o_tx_busy(busy_e), .o_uart_tx_done(done_e));

  uart_byte_tx #(.BAUD_CNT_MAX(B), .PARITY(1), .STOP_BITS(2)) u_odd (
    .i_sysclk(clk), .i_sysrst_n(rst_n), .i_tx_data(tx_data), .i_tx_start(start_o),
    .o_uart_tx(tx_o), .o_tx_busy(busy_o), .o_uart_tx_done(done_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which each done output is high.
  always @(posedge clk) begin
    if (done0)  done_cnt[0]++;
    if (done_e) done_cnt[1]++;
    if (done_o) done_cnt[2]++;
  end

  typedef struct {
    int         sel;     // 0 plain, 1 even/2 stop, 2 odd/2 stop
    logic [7:0] data;
    logic [11:0] bits;   // bit k = line value during frame bit k
    int         nbits;
    int         inject;  // frame bit after which a stray start is pulsed, -1 none
    string      name;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      1:       return tx_e;
      2:       return tx_o;
      default: return tx0;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1:       return busy_e;
      2:       return busy_o;
      default: return busy0;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      1:       return done_e;
      2:       return done_o;
      default: return done0;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      1:       start_e = v;
      2:       start_o = v;
      default: start0  = v;
    endcase
  endtask

  // Drive a start for one edge. Then scramble the data input to show that it
  // is ignored while busy.
  task automatic launch(input int sel, input logic [7:0] d);
    tx_data = d;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    tx_data = ~d;
  endtask

  // Entered #1 after the edge that accepted the start.
  task automatic frame_body(input int sel, input logic [11:0] exp, input int nbits,
                            input int inject, input bit chain, input logic [7:0] chain_d,
                            input string name);
    int   elapsed;
    int   w;
    int   dc0;
    bit   got_done;
    bit   busy_bad;
    dc0      = done_cnt[sel];
    busy_bad = 1'b0;
    check($sformatf("%s:latency_tx", name), get_tx(sel), 1'b0);
    check($sformatf("%s:latency_busy", name), get_busy(sel), 1'b1);
    elapsed = 0;
    for (int k = 0; k < nbits; k++) begin
      w = (k == 0) ? B / 2 : B;
      if (inject >= 0 && k == inject + 1) w = B - 1;
      repeat (w) @(posedge clk);
      #1;
      elapsed += w;
      check($sformatf("%s:bit%0d", name, k), get_tx(sel), exp[k]);
      if (get_busy(sel) !== 1'b1) busy_bad = 1'b1;
      if (k == inject) begin
        tx_data = 8'h33;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        elapsed++;
        if (get_busy(sel) !== 1'b1) busy_bad = 1'b1;
      end
    end
    check($sformatf("%s:busy_in_frame", name), busy_bad, 1'b0);
    got_done = 1'b0;
    for (int j = 0; j < 2 * B && !got_done; j++) begin
      @(posedge clk); #1;
      elapsed++;
      if (get_done(sel)) got_done = 1'b1;
    end
    check($sformatf("%s:done_seen", name), got_done, 1'b1);
    if (got_done) begin
      check($sformatf("%s:frame_clocks", name), elapsed, nbits * B);
      check($sformatf("%s:busy_at_done", name), get_busy(sel), 1'b0);
      check($sformatf("%s:tx_at_done", name), get_tx(sel), 1'b1);
    end
    if (chain) begin
      tx_data = chain_d;
      set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
    end else begin
      @(posedge clk); #1;
      check($sformatf("%s:done_one_cycle", name), get_done(sel), 1'b0);
    end
    check($sformatf("%s:done_count", name), done_cnt[sel] - dc0, 1);
  endtask

  initial begin
    int dc;
    vecs[0] = '{0, 8'h55, 12'b0010_1010_1010, 10, -1, "tx55"};
    vecs[1] = '{0, 8'hAA, 12'b0011_0101_0100, 10, -1, "txAA"};
    vecs[2] = '{0, 8'h0F, 12'b0010_0001_1110, 10,  4, "tx0F_ignore33"};
    vecs[3] = '{1, 8'h07, 12'b1110_0000_1110, 12, -1, "even07"};
    vecs[4] = '{2, 8'h07, 12'b1100_0000_1110, 12, -1, "odd07"};

    rst_n   = 1'b0;
    tx_data = 8'h00;
    start0  = 1'b0;
    start_e = 1'b0;
    start_o = 1'b0;

    #100;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset%0d:tx", s), get_tx(s), 1'b1);
      check($sformatf("reset%0d:busy", s), get_busy(s), 1'b0);
      check($sformatf("reset%0d:done", s), get_done(s), 1'b0);
    end
    #101 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].sel, vecs[i].data);
      frame_body(vecs[i].sel, vecs[i].bits, vecs[i].nbits, vecs[i].inject, 1'b0, 8'h00,
                 vecs[i].name);
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back: the second start is asserted in the done cycle.
    launch(0, 8'hAA);
    frame_body(0, 12'b0011_0101_0100, 10, -1, 1'b1, 8'h12, "b2b_first");
    frame_body(0, 12'b0010_0010_0100, 10, -1, 1'b0, 8'h00, "b2b_second");

    // Reset in the middle of data bit 3, which is low for 0x55.
    repeat (2) @(posedge clk); #1;
    launch(0, 8'h55);
    dc = done_cnt[0];
    repeat (B / 2 + 4 * B) @(posedge clk);
    #1;
    check("midrst:line_before", tx0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst:tx", tx0, 1'b1);
    check("midrst:busy", busy0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check("midrst:no_done", done_cnt[0] - dc, 0);
    launch(0, 8'hC3);
    frame_body(0, 12'b0011_1000_0110, 10, -1, 1'b0, 8'h00, "after_rst_C3");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net in case a wait above never returns.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, run did not finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
